uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
// Oversampling UART receiver. The serial line is synchronized, a falling
// edge is confirmed by sampling mid start bit, and the data bits, optional
// parity bit and stop bit are then sampled mid-bit using a 16x tick.
// A completed frame is presented on a valid/ready output holding register.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   tick_16x    one-clk enable at 16x baud; all bit timing counts these
//   rx          asynchronous serial input, idles high
//   rx_data     received word, first received bit in bit 0
//   rx_valid    rx_data / parity_err / frame_err are valid
//   rx_ready    consumer accepts the word
//   parity_err  parity mismatch for the held word
//   frame_err   stop bit sampled low for the held word
//   overrun     one-clk pulse when a completed frame is dropped
//   busy        receiver FSM is not idle
//   dbg_state_o current FSM state, for observation only
//
// Handshake: a word transfers on every clock where rx_valid && rx_ready.
// While rx_valid is high and not accepted, rx_data and both error flags
// hold stable. A frame completing in the same clock as an acceptance
// replaces the word and rx_valid stays high; a frame completing while the
// held word is not being accepted is dropped and overrun pulses.
module uart_rx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       ODD_INV  = (PARITY_ODD != 0);
  localparam state_e     AFTER_DATA = (PARITY_EN != 0) ? S_PARITY : S_STOP;

  state_e                 state_q;
  logic                   rx_s1_q, rx_s2_q;
  logic [3:0]             cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   perr_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   parity_err_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      cnt_q        <= 4'd0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      overrun_q <= 1'b0;

      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (tick_16x) begin
        // Free-running between sample points; each state clears it on entry
        // so that counter==7 lands mid start bit and counter==15 mid bit.
        cnt_q <= cnt_q + 4'd1;
        case (state_q)
          S_IDLE: begin
            if (!rx_s2_q) begin
              state_q <= S_START;
              cnt_q   <= 4'd0;
            end
          end
          S_START: begin
            if (cnt_q == 4'd7) begin
              if (!rx_s2_q) begin
                state_q   <= S_DATA;
                cnt_q     <= 4'd0;
                bit_cnt_q <= 4'd0;
                perr_q    <= 1'b0;
              end else begin
                state_q <= S_IDLE;  // glitch: line went back high
              end
            end
          end
          S_DATA: begin
            if (cnt_q == 4'd15) begin
              // Shift in from the top so the first bit ends up in bit 0.
              shift_q   <= {rx_s2_q, shift_q[DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= 4'd0;
                state_q   <= AFTER_DATA;
              end
            end
          end
          S_PARITY: begin
            if (cnt_q == 4'd15) begin
              perr_q  <= rx_s2_q ^ (^shift_q) ^ ODD_INV;
              state_q <= S_STOP;
            end
          end
          S_STOP: begin
            if (cnt_q == 4'd15) begin
              state_q <= S_IDLE;
              if (!rx_valid_q || rx_ready) begin
                rx_data_q    <= shift_q;
                parity_err_q <= perr_q;
                frame_err_q  <= !rx_s2_q;
                rx_valid_q   <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
